m68k_region_decoder: RTL and testbench

//  Parametrised, registered 68000 address decoder and bus-cycle controller for the

---
 rtl/m68k_region_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_m68k_region_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_region_decoder.sv
// m68k_region_decoder
//   Registered 68000 address decoder and bus-cycle controller. A table of
//   NUM_REGIONS base/mask entries, each with a direction filter and a
//   wait-state count, replaces fixed per-board range compares. The address
//   is latched on the sampled AS_n falling edge. A one-hot chip select is
//   driven, DTACK_n is produced after the region's wait states, and BERR_n
//   is raised on unmapped or externally stalled cycles.
//
// Ports
//   clk           system clock
//   reset_n       synchronous active-low reset
//   m68k_a        CPU byte address (bit 0 ignored)
//   m68k_as_n     address strobe
//   m68k_rw       1 = read, 0 = write
//   ext_dtack_n   external acknowledge for WAIT = 15 regions
//   cs            one-hot registered chip selects
//   cs_any        OR of cs
//   region_idx    index of the active region, 0 when none
//   m68k_dtack_n  data acknowledge to CPU
//   m68k_berr_n   bus error to CPU
//   cycle_start   one-clock pulse after the sampled AS_n falling edge
module m68k_region_decoder #(
   parameter int                            NUM_REGIONS  = 16,
   parameter int                            ADDR_W       = 24,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = '0,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK  = '1,
   parameter logic [2*NUM_REGIONS-1:0]      REGION_DIR   = '0,
   parameter logic [4*NUM_REGIONS-1:0]      REGION_WAIT  = '0,
   parameter int                            BERR_TIMEOUT = 64
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [ADDR_W-1:0]              m68k_a,
   input  logic                           m68k_as_n,
   input  logic                           m68k_rw,
   input  logic                           ext_dtack_n,
   output logic [NUM_REGIONS-1:0]         cs,
   output logic                           cs_any,
   output logic [$clog2(NUM_REGIONS)-1:0] region_idx,
   output logic                           m68k_dtack_n,
   output logic                           m68k_berr_n,
   output logic                           cycle_start
);

   localparam int IDX_W     = $clog2(NUM_REGIONS);
   localparam int CNT_W_MIN = $clog2(BERR_TIMEOUT) + 1;
   // Counter also holds wait counts up to 14, so never narrower than 4 bits.
   localparam int CNT_W     = (CNT_W_MIN < 4) ? 4 : CNT_W_MIN;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_EXT   = CNT_W'(BERR_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_NOMAP = CNT_W'(BERR_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_EXT,
      ST_ACK,
      ST_NOMAP,
      ST_BERR
   } state_t;

   state_t state, state_next;

   logic [CNT_W-1:0]       cnt, cnt_next;
   logic                   as_n_d;
   logic                   as_fall;
   logic                   unused_a0;

   logic [NUM_REGIONS-1:0] hit;
   logic [NUM_REGIONS-1:0] win_oh;
   logic [IDX_W-1:0]       win_idx;
   logic [3:0]             win_wait;
   logic                   win_found;

   logic [NUM_REGIONS-1:0] cs_next;
   logic                   cs_any_next;
   logic [IDX_W-1:0]       idx_next;
   logic                   dtack_next;
   logic                   berr_next;

   assign as_fall   = !m68k_as_n && as_n_d;
   assign unused_a0 = m68k_a[0];

   // Per-region address and direction match on word addresses.
   for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_hit
      localparam logic [ADDR_W-1:0] BASE = REGION_BASE[g*ADDR_W +: ADDR_W];
      localparam logic [ADDR_W-1:0] MASK = REGION_MASK[g*ADDR_W +: ADDR_W];
      localparam logic [1:0]        DIR  = REGION_DIR[2*g +: 2];

      logic addr_ok;
      logic dir_ok;

      assign addr_ok = (m68k_a[ADDR_W-1:1] & MASK[ADDR_W-1:1]) ==
                       (BASE[ADDR_W-1:1] & MASK[ADDR_W-1:1]);

      always_comb begin
         dir_ok = 1'b0;
         case (DIR)
            2'b00:   dir_ok = 1'b1;
            2'b01:   dir_ok = m68k_rw;
            2'b10:   dir_ok = !m68k_rw;
            default: dir_ok = 1'b0;
         endcase
      end

      assign hit[g] = addr_ok && dir_ok;
   end

   // Lowest matching index wins, keeping cs one-hot on overlaps.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_wait  = '0;
      win_oh    = '0;
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
         if (hit[i] && !win_found) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
            win_wait  = REGION_WAIT[4*i +: 4];
            win_oh[i] = 1'b1;
         end
      end
   end

   // Outputs are registered from next-state values so that cs and a
   // zero-wait DTACK appear on the same clock.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      cs_next     = cs;
      cs_any_next = cs_any;
      idx_next    = region_idx;
      dtack_next  = m68k_dtack_n;
      berr_next   = m68k_berr_n;

      if (state == ST_IDLE) begin
         if (as_fall) begin
            if (win_found) begin
               cs_next     = win_oh;
               cs_any_next = 1'b1;
               idx_next    = win_idx;
               cnt_next    = CNT_W'(win_wait);
               if (win_wait == 4'd15) begin
                  state_next = ST_EXT;
                  cnt_next   = CNT_EXT;
               end else if (win_wait == 4'd0) begin
                  state_next = ST_ACK;
                  dtack_next = 1'b0;
               end else begin
                  state_next = ST_WAIT;
               end
            end else begin
               state_next = ST_NOMAP;
               cnt_next   = CNT_NOMAP;
            end
         end
      end else if (m68k_as_n) begin
         // Abort/termination outranks expiry and external acknowledge.
         state_next  = ST_IDLE;
         cnt_next    = '0;
         cs_next     = '0;
         cs_any_next = 1'b0;
         idx_next    = '0;
         dtack_next  = 1'b1;
         berr_next   = 1'b1;
      end else begin
         case (state)
            ST_WAIT: begin
               if (cnt <= CNT_ONE) begin
                  state_next = ST_ACK;
                  dtack_next = 1'b0;
               end else begin
                  cnt_next = cnt - CNT_ONE;
               end
            end
            ST_EXT: begin
               if (!ext_dtack_n) begin
                  state_next = ST_ACK;
                  dtack_next = 1'b0;
               end else if (cnt <= CNT_ONE) begin
                  state_next = ST_BERR;
                  berr_next  = 1'b0;
               end else begin
                  cnt_next = cnt - CNT_ONE;
               end
            end
            ST_NOMAP: begin
               if (cnt <= CNT_ONE) begin
                  state_next = ST_BERR;
                  berr_next  = 1'b0;
               end else begin
                  cnt_next = cnt - CNT_ONE;
               end
            end
            default: begin
               state_next = state;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         as_n_d       <= 1'b1;
         cs           <= '0;
         cs_any       <= 1'b0;
         region_idx   <= '0;
         m68k_dtack_n <= 1'b1;
         m68k_berr_n  <= 1'b1;
         cycle_start  <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         as_n_d       <= m68k_as_n;
         cs           <= cs_next;
         cs_any       <= cs_any_next;
         region_idx   <= idx_next;
         m68k_dtack_n <= dtack_next;
         m68k_berr_n  <= berr_next;
         cycle_start  <= as_fall;
      end
   end

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Testbench for m68k_region_decoder: directed bus cycles plus randomized
// cycles compared cycle by cycle against a behavioural decode/timing model.
module tb_m68k_region_decoder;

   localparam int NR = 16;
   localparam int AW = 24;
   localparam int TO = 64;

   // Entries listed 15 down to 0.
   localparam logic [NR*AW-1:0] P_BASE = {
      24'h000000, 24'h000000, 24'h000000, 24'hC00000,
      24'hC00000, 24'h000000, 24'h900000, 24'hA00000,
      24'h500000, 24'h800000, 24'h700000, 24'h600000,
      24'h400000, 24'h080000, 24'h080000, 24'h000000};
   localparam logic [NR*AW-1:0] P_MASK = {
      24'h000000, 24'h000000, 24'h000000, 24'hFE0000,
      24'hFFFFFF, 24'hFF0000, 24'hFFFF00, 24'hFF8000,
      24'hFF0000, 24'hF00000, 24'hFFF000, 24'hFF0000,
      24'hFFE000, 24'hFFFFF8, 24'hFFFFFC, 24'hFC0000};
   localparam logic [2*NR-1:0] P_DIR = {
      2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01,
      2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
   localparam logic [4*NR-1:0] P_WAIT = {
      4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 4'd7, 4'd1, 4'd15,
      4'd0, 4'd14, 4'd5, 4'd15, 4'd3, 4'd2, 4'd1, 4'd0};

   logic          clk;
   logic          reset_n;
   logic [AW-1:0] m68k_a;
   logic          m68k_as_n;
   logic          m68k_rw;
   logic          ext_dtack_n;
   logic [NR-1:0] cs;
   logic          cs_any;
   logic [3:0]    region_idx;
   logic          m68k_dtack_n;
   logic          m68k_berr_n;
   logic          cycle_start;

   int n_checks = 0;
   int n_errors = 0;

   m68k_region_decoder #(
      .NUM_REGIONS (NR),
      .ADDR_W      (AW),
      .REGION_BASE (P_BASE),
      .REGION_MASK (P_MASK),
      .REGION_DIR  (P_DIR),
      .REGION_WAIT (P_WAIT),
      .BERR_TIMEOUT(TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .m68k_a      (m68k_a),
      .m68k_as_n   (m68k_as_n),
      .m68k_rw     (m68k_rw),
      .ext_dtack_n (ext_dtack_n),
      .cs          (cs),
      .cs_any      (cs_any),
      .region_idx  (region_idx),
      .m68k_dtack_n(m68k_dtack_n),
      .m68k_berr_n (m68k_berr_n),
      .cycle_start (cycle_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Model: first region whose masked word address matches and whose
   // direction filter admits the access; -1 when unmapped.
   function automatic int ref_region(input logic [AW-1:0] a, input logic rw);
      logic [AW-1:0] b;
      logic [AW-1:0] m;
      logic [1:0]    d;
      bit            ok;
      for (int i = 0; i < NR; i++) begin
         b  = P_BASE[i*AW +: AW];
         m  = P_MASK[i*AW +: AW];
         d  = P_DIR[i*2 +: 2];
         ok = (((a ^ b) & m & 24'hFFFFFE) == 24'h0);
         if (d == 2'b01) ok = ok && rw;
         if (d == 2'b10) ok = ok && !rw;
         if (d == 2'b11) ok = 1'b0;
         if (ok) return i;
      end
      return -1;
   endfunction

   // Model: clock (counted from as_fall, cs visible at 1) at which the
   // cycle terminates, and whether it terminates with bus error.
   task automatic ref_term(input int idx, input int ext_d, output int lat, output bit is_berr);
      int w;
      if (idx < 0) begin
         lat     = TO;
         is_berr = 1'b1;
      end else begin
         w = int'(P_WAIT[idx*4 +: 4]);
         if (w == 15) begin
            if (ext_d >= 0 && ext_d <= TO - 1) begin
               lat     = ext_d + 2;
               is_berr = 1'b0;
            end else begin
               lat     = TO + 1;
               is_berr = 1'b1;
            end
         end else begin
            lat     = w + 1;
            is_berr = 1'b0;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cs"}, 32'(cs), 32'h0);
      check({tag, "_cs_any"}, 32'(cs_any), 32'h0);
      check({tag, "_idx"}, 32'(region_idx), 32'h0);
      check({tag, "_dtack_n"}, 32'(m68k_dtack_n), 32'h1);
      check({tag, "_berr_n"}, 32'(m68k_berr_n), 32'h1);
   endtask

   // Starts at a negedge. ext_d < 0: ext_dtack_n never asserted.
   // abort_c >= 1: AS_n raised at clock abort_c if that precedes termination.
   task automatic run_cycle(input logic [AW-1:0] a, input logic rw, input int ext_d,
                            input int abort_c, input int hold);
      int            idx;
      int            lat;
      int            r;
      bit            is_berr;
      bit            aborted;
      logic [NR-1:0] exp_cs;
      idx = ref_region(a, rw);
      ref_term(idx, ext_d, lat, is_berr);
      exp_cs  = (idx >= 0) ? (NR'(1) << idx) : '0;
      aborted = (abort_c >= 1) && (abort_c < lat);
      r       = aborted ? abort_c : lat + hold;
      m68k_a      = a;
      m68k_rw     = rw;
      m68k_as_n   = 1'b0;
      ext_dtack_n = 1'b1;
      for (int t = 1; t <= r; t++) begin
         @(negedge clk);
         check("cycle_start", 32'(cycle_start), 32'(t == 1));
         check("cs", 32'(cs), 32'(exp_cs));
         check("cs_any", 32'(cs_any), 32'(idx >= 0));
         check("region_idx", 32'(region_idx), (idx >= 0) ? 32'(idx) : 32'h0);
         check("dtack_n", 32'(m68k_dtack_n), 32'(!(!is_berr && t >= lat)));
         check("berr_n", 32'(m68k_berr_n), 32'(!(is_berr && t >= lat)));
         if (t == 1) begin
            m68k_a  = AW'($urandom);
            m68k_rw = 1'($urandom);
         end
         if (ext_d >= 0 && t == ext_d + 1) ext_dtack_n = 1'b0;
         if (t == r) m68k_as_n = 1'b1;
      end
      @(negedge clk);
      check_idle("release");
      check("release_cycle_start", 32'(cycle_start), 32'h0);
      ext_dtack_n = 1'b1;
   endtask

   task automatic idle_gap(input int n);
      repeat (n) begin
         @(negedge clk);
         check_idle("gap");
         check("gap_cycle_start", 32'(cycle_start), 32'h0);
      end
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [AW-1:0] m;
      int            ri;
      int            ext_d;
      int            abort_c;

      reset_n     = 1'b0;
      m68k_a      = '0;
      m68k_as_n   = 1'b1;
      m68k_rw     = 1'b1;
      ext_dtack_n = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check("reset_cycle_start", 32'(cycle_start), 32'h0);
      reset_n = 1'b1;
      idle_gap(1);

      // Region 0, zero wait.
      run_cycle(24'h012344, 1'b1, -1, -1, 2);
      // Region 3, three waits, write.
      run_cycle(24'h401FFE, 1'b0, -1, -1, 1);
      // Overlap: read-only region 1 wins on read, region 2 on write.
      run_cycle(24'h080002, 1'b1, -1, -1, 0);
      run_cycle(24'h080002, 1'b0, -1, -1, 0);
      // Unmapped (region 7 disabled) -> bus error after timeout.
      run_cycle(24'h500000, 1'b1, -1, -1, 1);
      // External acknowledge five clocks after cs, then external timeout.
      run_cycle(24'h600000, 1'b1, 5, -1, 1);
      run_cycle(24'h600010, 1'b0, -1, -1, 0);
      // External acknowledge on the very last clock before timeout.
      run_cycle(24'h600020, 1'b1, TO - 1, -1, 0);
      // Abort on the clock the wait counter would expire.
      run_cycle(24'h401000, 1'b1, -1, 3, 0);
      idle_gap(2);

      // Reset in the middle of an acknowledged cycle.
      m68k_a    = 24'h000100;
      m68k_rw   = 1'b1;
      m68k_as_n = 1'b0;
      @(negedge clk);
      check("rst_ack_dtack_n", 32'(m68k_dtack_n), 32'h0);
      check("rst_ack_cs", 32'(cs), 32'h1);
      reset_n = 1'b0;
      @(negedge clk);
      check_idle("midack_reset");
      check("midack_reset_cycle_start", 32'(cycle_start), 32'h0);
      m68k_as_n = 1'b1;
      reset_n   = 1'b1;
      idle_gap(1);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            a = AW'($urandom);
         end else begin
            ri = int'($urandom_range(0, 12));
            m  = P_MASK[ri*AW +: AW];
            a  = (P_BASE[ri*AW +: AW] & m) | (AW'($urandom) & ~m);
         end
         case ($urandom_range(0, 3))
            0:       ext_d = -1;
            1:       ext_d = int'($urandom_range(TO - 2, TO + 1));
            default: ext_d = int'($urandom_range(0, 12));
         endcase
         abort_c = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 16)) : -1;
         run_cycle(a, 1'($urandom), ext_d, abort_c, int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
